mult_shift_add_ctrl: RTL and testbench

//  Sequential unsigned N x N -> 2N multiplier built around one adder_full_n #(.n(N)) instance.
//  - Sequences the shared N-bit adder over N add/shift steps.
//  - Presents a valid/ready handshake on both operand input and product output.
//  - Sits between a requester and the arithmetic datapath as the datapath's scheduler/controller.

---
 rtl/mult_shift_add_ctrl.sv | 75 +++++++
 tb/tb_mult_shift_add_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mult_shift_add_ctrl.sv
// mult_shift_add_ctrl: sequential N x N unsigned shift-add multiplier with valid/ready handshakes
module adder_full_n #(
  parameter int n = 8
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{n{1'b0}}, cin};
endmodule

module mult_shift_add_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);
  localparam int CNT_W = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] a_r, p_hi, p_lo, sum;
  logic carry;
  logic [CNT_W-1:0] count;
  logic last;
  assign last = count == CNT_W'(N - 1);
  adder_full_n #(.n(N)) u_add (
    .x(p_hi),
    .y(p_lo[0] ? a_r : '0),
    .cin(1'b0),
    .sum(sum),
    .cout(carry)
  );
  // state register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and handshake outputs
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && in_valid) ? RUN :
              (state == RUN && last) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
  end
  // operand capture, add/shift steps, and final product latch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      p_hi <= '0;
      p_lo <= '0;
      count <= '0;
      product <= '0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      p_lo <= b;
      p_hi <= '0;
      count <= '0;
    end else if (state == RUN) begin
      {p_hi, p_lo} <= {carry, sum, p_lo[N-1:1]};
      count <= count + CNT_W'(1);
      if (last) product <= {carry, sum, p_lo[N-1:1]};
    end
endmodule

// File: tb/tb_mult_shift_add_ctrl.sv
// tb_mult_shift_add_ctrl: scoreboard bench for the shift-add multiplier
module tb_mult_shift_add_ctrl;
  localparam int N = 8;
  logic clk = 0;
  logic rst, in_valid, out_ready;
  logic [N-1:0] a, b;
  logic in_ready, out_valid, busy;
  logic [2*N-1:0] product;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  logic prev_ov = 0;
  logic [2*N-1:0] exp_q[$];

  mult_shift_add_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // cycle counter and acceptance timestamp (value of cyc right after the accepting edge)
  always @(posedge clk) begin
    if (in_valid && in_ready && !rst) acc <= cyc + 1;
    cyc <= cyc + 1;
  end

  // monitor: latency on rising out_valid, product check on each delivered result
  always @(negedge clk) begin
    if (out_valid && !prev_ov) chk("latency", cyc - acc, N);
    if (out_valid && out_ready) begin
      if (exp_q.size() > 0) chk("product", {16'd0, product}, {16'd0, exp_q.pop_front()});
      else begin
        checks++;
        errors++;
        $display("FAIL product got %0d expected none", product);
      end
    end
    prev_ov <= out_valid;
  end

  task automatic issue(input logic [N-1:0] xa, input logic [N-1:0] xb);
    int t;
    @(negedge clk);
    a = xa;
    b = xb;
    in_valid = 1;
    exp_q.push_back(16'(xa) * 16'(xb));
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 expected 1");
    end
    @(negedge clk);
    in_valid = 0;
    a = N'($urandom);
    b = N'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    int t;
    rst = 1;
    in_valid = 0;
    out_ready = 1;
    a = 0;
    b = 0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    @(negedge clk);
    rst = 0;
    issue(13, 11);
    drain();
    issue(255, 255);
    issue(255, 1);
    issue(1, 255);
    issue(0, 200);
    issue(200, 0);
    drain();
    out_ready = 0;
    issue(100, 3);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_product", product, 300);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    issue(7, 9);
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 0;
    issue(7, 9);
    drain();
    for (int i = 0; i < 200; i++) issue(N'($urandom), N'($urandom));
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
